// File: rtl/exec_alu_unit_pkg.sv
// Shared definitions for the execute-stage ALU: control encodings, ALUOp
// codes, R-type funct constants and datapath widths.
package alu_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned CTRL_W  = 4;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned OP_W    = 2;

    // ALU control encodings produced by the decoder
    typedef enum logic [CTRL_W-1:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100
    } alu_ctrl_e;

    // Main-control ALUOp codes
    typedef enum logic [OP_W-1:0] {
        OP_LWSW  = 2'b00,
        OP_BEQ   = 2'b01,
        OP_RTYPE = 2'b10,
        OP_ORI   = 2'b11
    } alu_op_e;

    // R-type funct field values
    localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FUNCT_NOR = 6'b100111;
    localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'b101010;

endpackage

// File: rtl/exec_alu_unit_if.sv
// Operand/control bundle into the execute unit and registered results out.
//   master: drives valid_in, a, b, funct, alu_op, pc, offset; sees results
//   slave : the execute unit; drives result, zero, ovf, branch_target,
//           alu_ctrl, valid_out
interface exec_alu_unit_if #(
    parameter int unsigned WIDTH = 32
);
    import alu_pkg::*;

    logic                 valid_in;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [FUNCT_W-1:0]   funct;
    logic [OP_W-1:0]      alu_op;
    logic [WIDTH-1:0]     pc;
    logic [WIDTH-1:0]     offset;

    logic [WIDTH-1:0]     result;
    logic                 zero;
    logic                 ovf;
    logic [WIDTH-1:0]     branch_target;
    logic [CTRL_W-1:0]    alu_ctrl;
    logic                 valid_out;

    modport master (
        output valid_in, a, b, funct, alu_op, pc, offset,
        input  result, zero, ovf, branch_target, alu_ctrl, valid_out
    );

    modport slave (
        input  valid_in, a, b, funct, alu_op, pc, offset,
        output result, zero, ovf, branch_target, alu_ctrl, valid_out
    );
endinterface

// File: rtl/exec_alu_unit_decode.sv
// ALU-control decoder: main-control ALUOp plus R-type funct -> 4-bit ALU
// control. Purely combinational.
//   alu_op     in  ALUOp from main control
//   funct      in  instruction funct field
//   alu_ctrl_c out decoded ALU control
module alu_decode
    import alu_pkg::*;
(
    input  logic [OP_W-1:0]    alu_op,
    input  logic [FUNCT_W-1:0] funct,
    output logic [CTRL_W-1:0]  alu_ctrl_c
);

    always_comb begin
        alu_ctrl_c = ALU_ADD;
        case (alu_op)
            OP_LWSW: alu_ctrl_c = ALU_ADD;
            OP_BEQ:  alu_ctrl_c = ALU_SUB;
            OP_ORI:  alu_ctrl_c = ALU_OR;
            OP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: alu_ctrl_c = ALU_ADD;
                    FUNCT_SUB: alu_ctrl_c = ALU_SUB;
                    FUNCT_AND: alu_ctrl_c = ALU_AND;
                    FUNCT_OR:  alu_ctrl_c = ALU_OR;
                    FUNCT_NOR: alu_ctrl_c = ALU_NOR;
                    FUNCT_SLT: alu_ctrl_c = ALU_SLT;
                    default:   alu_ctrl_c = ALU_ADD;
                endcase
            end
            default: alu_ctrl_c = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/exec_alu_unit.sv
// Registered execute stage: ALU-control decode, 32-bit ALU with zero and
// signed-overflow flags, and the branch-target adder, all captured in one
// output register stage with a valid bit.
//   clk   in  rising-edge clock
//   reset in  asynchronous active-high reset
//   bus   slave side of exec_alu_unit_if (operands in, registered results out)
module exec_alu_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic            clk,
    input  logic            reset,
    exec_alu_unit_if.slave  bus
);

    localparam int unsigned MSB = WIDTH - 1;

    logic [CTRL_W-1:0] ctrl_c;
    logic [WIDTH-1:0]  sum_c;
    logic [WIDTH-1:0]  diff_c;
    logic [WIDTH-1:0]  target_c;
    logic [WIDTH-1:0]  result_c;
    logic              ovf_c;
    logic              slt_c;

    logic [WIDTH-1:0]  result_q;
    logic              zero_q;
    logic              ovf_q;
    logic [WIDTH-1:0]  target_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic              valid_q;

    alu_decode u_decode (
        .alu_op     (bus.alu_op),
        .funct      (bus.funct),
        .alu_ctrl_c (ctrl_c)
    );

    assign sum_c    = bus.a + bus.b;
    assign diff_c   = bus.a - bus.b;
    assign target_c = bus.pc + bus.offset;
    // Direct signed compare, so SLT stays right when a - b overflows
    assign slt_c    = $signed(bus.a) < $signed(bus.b);

    // ALU function select and overflow flag
    always_comb begin
        result_c = '0;
        ovf_c    = 1'b0;
        case (ctrl_c)
            ALU_AND: result_c = bus.a & bus.b;
            ALU_OR:  result_c = bus.a | bus.b;
            ALU_NOR: result_c = ~(bus.a | bus.b);
            ALU_SLT: result_c = WIDTH'(slt_c);
            ALU_ADD: begin
                result_c = sum_c;
                ovf_c    = (bus.a[MSB] == bus.b[MSB]) && (sum_c[MSB] != bus.a[MSB]);
            end
            ALU_SUB: begin
                result_c = diff_c;
                ovf_c    = (bus.a[MSB] != bus.b[MSB]) && (diff_c[MSB] != bus.a[MSB]);
            end
            default: result_c = '0;
        endcase
    end

    // Output stage: valid follows every cycle, data loads only on valid_in
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
            target_q <= '0;
            ctrl_q   <= ALU_ADD;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= bus.valid_in;
            if (bus.valid_in) begin
                result_q <= result_c;
                zero_q   <= ~|result_c;
                ovf_q    <= ovf_c;
                target_q <= target_c;
                ctrl_q   <= ctrl_c;
            end
        end
    end

    assign bus.result        = result_q;
    assign bus.zero          = zero_q;
    assign bus.ovf           = ovf_q;
    assign bus.branch_target = target_q;
    assign bus.alu_ctrl      = ctrl_q;
    assign bus.valid_out     = valid_q;

endmodule

// File: tb/tb_exec_alu_unit.sv
// Scoreboard bench for exec_alu_unit: the driver pushes model expectations,
// a monitor pops and compares whenever valid_out is seen, and checks that
// data outputs hold while valid_out is low.
module tb_exec_alu_unit;

    typedef struct {
        logic [31:0] result;
        logic        zero;
        logic        ovf;
        logic [31:0] bt;
        logic [3:0]  ctrl;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    exec_alu_unit_if #(.WIDTH(32)) bus ();

    exec_alu_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model from the instruction semantics using wide signed math
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [5:0] funct, input logic [1:0] op,
                                   input logic [31:0] pc, input logic [31:0] off);
        exp_t   e;
        string  mn;
        longint sa;
        longint sb;
        longint r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'd0: mn = "add";
            2'd1: mn = "sub";
            2'd3: mn = "or";
            default: begin
                case (funct)
                    6'd32:   mn = "add";
                    6'd34:   mn = "sub";
                    6'd36:   mn = "and";
                    6'd37:   mn = "or";
                    6'd39:   mn = "nor";
                    6'd42:   mn = "slt";
                    default: mn = "add";
                endcase
            end
        endcase
        e.ovf = 1'b0;
        case (mn)
            "add": begin
                r = sa + sb;
                e.result = 32'(r);
                e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
                e.ctrl = 4'd2;
            end
            "sub": begin
                r = sa - sb;
                e.result = 32'(r);
                e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
                e.ctrl = 4'd6;
            end
            "and": begin e.result = a & b;    e.ctrl = 4'd0;  end
            "or":  begin e.result = a | b;    e.ctrl = 4'd1;  end
            "nor": begin e.result = ~(a | b); e.ctrl = 4'd12; end
            default: begin e.result = (sa < sb) ? 32'd1 : 32'd0; e.ctrl = 4'd7; end
        endcase
        e.zero = (e.result == 32'd0);
        e.bt   = 32'(longint'(pc) + longint'(off));
        return e;
    endfunction

    // Drive one cycle of stimulus at the falling edge; queue expectation if valid
    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] funct, input logic [1:0] op,
                         input logic [31:0] pc, input logic [31:0] off);
        @(negedge clk);
        bus.valid_in = v;
        bus.a        = a;
        bus.b        = b;
        bus.funct    = funct;
        bus.alu_op   = op;
        bus.pc       = pc;
        bus.offset   = off;
        if (v && !reset) exp_q.push_back(model(a, b, funct, op, pc, off));
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 6))
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'h0000_0000;
            3: return 32'hFFFF_FFFF;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [5:0] rnd_funct();
        logic [5:0] tbl [7];
        tbl = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42, 6'd0};
        if ($urandom_range(0, 7) == 0) return 6'($urandom);
        return tbl[$urandom_range(0, 5)];
    endfunction

    // Monitor: pops on valid_out, otherwise expects the last loaded values held
    initial begin
        exp_t held;
        exp_t e;
        held = '{result: 32'd0, zero: 1'b1, ovf: 1'b0, bt: 32'd0, ctrl: 4'd2};
        forever begin
            after_edge();
            if (reset) begin
                held = '{result: 32'd0, zero: 1'b1, ovf: 1'b0, bt: 32'd0, ctrl: 4'd2};
            end else begin
                if (bus.valid_out) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_valid_out", 32'd1, 32'd0);
                        e = held;
                    end else begin
                        e = exp_q.pop_front();
                    end
                    held = e;
                end
                check("mon_result", bus.result, held.result);
                check("mon_zero", 32'(bus.zero), 32'(held.zero));
                check("mon_ovf", 32'(bus.ovf), 32'(held.ovf));
                check("mon_branch_target", bus.branch_target, held.bt);
                check("mon_alu_ctrl", 32'(bus.alu_ctrl), 32'(held.ctrl));
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_result"}, bus.result, 32'd0);
        check({tag, "_zero"}, 32'(bus.zero), 32'd1);
        check({tag, "_ovf"}, 32'(bus.ovf), 32'd0);
        check({tag, "_branch_target"}, bus.branch_target, 32'd0);
        check({tag, "_alu_ctrl"}, 32'(bus.alu_ctrl), 32'd2);
        check({tag, "_valid_out"}, 32'(bus.valid_out), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.valid_in = 1'b0;
        bus.a = '0; bus.b = '0; bus.funct = '0; bus.alu_op = '0;
        bus.pc = '0; bus.offset = '0;
        #2;
        check_reset_vals("por");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // ADD overflow
        drive(1'b1, 32'h7FFF_FFFF, 32'd1, 6'b100000, 2'b10, 32'h100, 32'h4);
        after_edge();
        check("addovf_result", bus.result, 32'h8000_0000);
        check("addovf_ovf", 32'(bus.ovf), 32'd1);
        check("addovf_zero", 32'(bus.zero), 32'd0);
        check("addovf_ctrl", 32'(bus.alu_ctrl), 32'd2);
        check("addovf_valid", 32'(bus.valid_out), 32'd1);

        // BEQ subtract to zero with branch target
        drive(1'b1, 32'h1234_5678, 32'h1234_5678, 6'd0, 2'b01, 32'h40, 32'h10);
        after_edge();
        check("beq_result", bus.result, 32'd0);
        check("beq_zero", 32'(bus.zero), 32'd1);
        check("beq_ovf", 32'(bus.ovf), 32'd0);
        check("beq_target", bus.branch_target, 32'h50);
        check("beq_ctrl", 32'(bus.alu_ctrl), 32'd6);

        // SLT where a - b overflows
        drive(1'b1, 32'h8000_0000, 32'd1, 6'b101010, 2'b10, 32'd0, 32'd0);
        after_edge();
        check("slt_result", bus.result, 32'd1);
        check("slt_ovf", 32'(bus.ovf), 32'd0);
        check("slt_ctrl", 32'(bus.alu_ctrl), 32'd7);

        // Logic ops
        drive(1'b1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 6'b100100, 2'b10, 32'd0, 32'd0);
        after_edge();
        check("and_result", bus.result, 32'h00F0_00F0);
        drive(1'b1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 6'b100101, 2'b10, 32'd0, 32'd0);
        after_edge();
        check("or_result", bus.result, 32'hFFF0_FFF0);
        drive(1'b1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 6'b100111, 2'b10, 32'd0, 32'd0);
        after_edge();
        check("nor_result", bus.result, 32'h000F_000F);
        check("nor_ctrl", 32'(bus.alu_ctrl), 32'd12);

        // Unknown funct falls back to ADD, then hold over idle cycles
        drive(1'b1, 32'd5, 32'd7, 6'b111111, 2'b10, 32'h200, 32'h8);
        after_edge();
        check("unk_result", bus.result, 32'd12);
        check("unk_ctrl", 32'(bus.alu_ctrl), 32'd2);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, $urandom, $urandom, 6'b100010, 2'($urandom), $urandom, $urandom);
            after_edge();
            check("hold_result", bus.result, 32'd12);
            check("hold_target", bus.branch_target, 32'h208);
            check("hold_valid", 32'(bus.valid_out), 32'd0);
        end

        // Randomized traffic, mostly back-to-back
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, rnd_operand(), rnd_operand(), rnd_funct(),
                  2'($urandom), $urandom, $urandom);
        end

        // Reset asserted between edges clears outputs immediately
        drive(1'b1, 32'd1, 32'd1, 6'b100000, 2'b00, 32'h1000, 32'h20);
        drive(1'b0, 32'd0, 32'd0, 6'd0, 2'b00, 32'd0, 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // First capture after reset release
        drive(1'b1, 32'd3, 32'd9, 6'b100010, 2'b10, 32'h10, 32'hFFFF_FFF0);
        after_edge();
        check("post_rst_result", bus.result, 32'hFFFF_FFFA);
        check("post_rst_target", bus.branch_target, 32'd0);
        check("post_rst_valid", 32'(bus.valid_out), 32'd1);

        drive(1'b0, 32'd0, 32'd0, 6'd0, 2'b00, 32'd0, 32'd0);
        after_edge();
        after_edge();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
